rev_add_seq: RTL and testbench

REV_ADD_SEQ -- requirements
Module: rev_add_seq

---
 rtl/rev_pkg.sv | 25 ++
 rtl/rev_chunk_add.sv | 40 ++++
 rtl/rev_add_seq.sv | 172 +++++++++++++++++
 tb/tb_rev_add_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rev_pkg.sv
// Shared types and helpers for the dual-rail reversible adder.
package rev_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic t;
    logic n;
  } dr_t;

  function automatic dr_t dr_null();
    return '0;
  endfunction

  // A rail pair is a legal code only when the two rails differ.
  function automatic logic dr_invalid(input logic t, input logic n);
    return t == n;
  endfunction

endpackage

// File: rtl/rev_chunk_add.sv
// Combinational CHUNK-bit dual-rail add/subtract slice with carry (borrow) in/out.
module rev_chunk_add
  import rev_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic             sub,
  input  logic [CHUNK-1:0] a_t,
  input  logic [CHUNK-1:0] a_n,
  input  logic [CHUNK-1:0] b_t,
  input  logic [CHUNK-1:0] b_n,
  input  dr_t              cin,
  output logic [CHUNK-1:0] s_t,
  output logic [CHUNK-1:0] s_n,
  output dr_t              cout
);

  logic [CHUNK-1:0] a_v;
  logic [CHUNK-1:0] b_v;
  logic             c_v;
  logic [CHUNK:0]   s_full;

  assign a_v = a_t & ~a_n;
  assign b_v = b_t & ~b_n;
  assign c_v = cin.t & ~cin.n;

  // In subtract mode the top bit of the widened difference is the borrow.
  always_comb begin
    s_full = '0;
    if (sub)
      s_full = {1'b0, a_v} - {1'b0, b_v} - {{CHUNK{1'b0}}, c_v};
    else
      s_full = {1'b0, a_v} + {1'b0, b_v} + {{CHUNK{1'b0}}, c_v};
  end

  assign s_t  = s_full[CHUNK-1:0];
  assign s_n  = ~s_full[CHUNK-1:0];
  assign cout = dr_t'{t: s_full[CHUNK], n: ~s_full[CHUNK]};

endmodule

// File: rtl/rev_add_seq.sv
// Sequential dual-rail reversible adder: forward add / backward uncompute, CHUNK bits per cycle.
module rev_add_seq
  import rev_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_t,
  input  logic [WIDTH-1:0] a_n,
  input  logic [WIDTH-1:0] b_t,
  input  logic [WIDTH-1:0] b_n,
  input  logic             cin_t,
  input  logic             cin_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r_t,
  output logic [WIDTH-1:0] r_n,
  output logic [WIDTH-1:0] bo_t,
  output logic [WIDTH-1:0] bo_n,
  output logic             cout_t,
  output logic             cout_n,
  output logic             err
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_e           state_q;
  logic             in_ready_q, out_valid_q, err_q;
  logic             mode_q, cin_t_q, cin_n_q, carry_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_t_q, a_n_q, b_t_q, b_n_q;
  logic [WIDTH-1:0] res_t_q, res_n_q, res_t_d, res_n_d;
  logic [WIDTH-1:0] r_t_q, r_n_q, bo_t_q, bo_n_q;
  dr_t              cout_q;

  logic [CHUNK-1:0] s_t, s_n;
  dr_t              co;
  logic             bad;
  logic             last;

  rev_chunk_add #(.CHUNK(CHUNK)) u_slice (
    .sub  (mode_q),
    .a_t  (a_t_q[k_q*CHUNK +: CHUNK]),
    .a_n  (a_n_q[k_q*CHUNK +: CHUNK]),
    .b_t  (b_t_q[k_q*CHUNK +: CHUNK]),
    .b_n  (b_n_q[k_q*CHUNK +: CHUNK]),
    .cin  (dr_t'{t: carry_q, n: ~carry_q}),
    .s_t  (s_t),
    .s_n  (s_n),
    .cout (co)
  );

  always_comb begin
    bad = dr_invalid(cin_t_q, cin_n_q);
    for (int unsigned i = 0; i < WIDTH; i++)
      bad = bad | dr_invalid(a_t_q[i], a_n_q[i]) | dr_invalid(b_t_q[i], b_n_q[i]);
  end

  always_comb begin
    res_t_d = res_t_q;
    res_n_d = res_n_q;
    res_t_d[k_q*CHUNK +: CHUNK] = s_t;
    res_n_d[k_q*CHUNK +: CHUNK] = s_n;
  end

  assign last = (k_q == KW'(NCH - 1));

  // Output rails are only loaded on entry to DONE, so they sit at the null spacer otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      mode_q      <= 1'b0;
      cin_t_q     <= 1'b0;
      cin_n_q     <= 1'b0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      a_t_q       <= '0;
      a_n_q       <= '0;
      b_t_q       <= '0;
      b_n_q       <= '0;
      res_t_q     <= '0;
      res_n_q     <= '0;
      r_t_q       <= '0;
      r_n_q       <= '0;
      bo_t_q      <= '0;
      bo_n_q      <= '0;
      cout_q      <= dr_null();
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mode_q     <= mode;
            a_t_q      <= a_t;
            a_n_q      <= a_n;
            b_t_q      <= b_t;
            b_n_q      <= b_n;
            cin_t_q    <= cin_t;
            cin_n_q    <= cin_n;
            in_ready_q <= 1'b0;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (bad) begin
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            bo_t_q      <= b_t_q;
            bo_n_q      <= b_n_q;
            state_q     <= DONE;
          end else begin
            k_q     <= '0;
            carry_q <= cin_t_q;
            res_t_q <= '0;
            res_n_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_t_q <= res_t_d;
          res_n_q <= res_n_d;
          carry_q <= co.t;
          k_q     <= k_q + KW'(1);
          if (last) begin
            r_t_q       <= res_t_d;
            r_n_q       <= res_n_d;
            cout_q      <= co;
            bo_t_q      <= b_t_q;
            bo_n_q      <= b_n_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            r_t_q       <= '0;
            r_n_q       <= '0;
            bo_t_q      <= '0;
            bo_n_q      <= '0;
            cout_q      <= dr_null();
            carry_q     <= 1'b0;
            k_q         <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign r_t       = r_t_q;
  assign r_n       = r_n_q;
  assign bo_t      = bo_t_q;
  assign bo_n      = bo_n_q;
  assign cout_t    = cout_q.t;
  assign cout_n    = cout_q.n;

endmodule

// File: tb/tb_rev_add_seq.sv
// Directed self-checking bench for rev_add_seq (16/4 and 32/8 configurations).
module tb_rev_add_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, mode, cin_t, cin_n;
  logic        out_valid, out_ready, cout_t, cout_n, err;
  logic [15:0] a_t, a_n, b_t, b_n, r_t, r_n, bo_t, bo_n;

  logic        in_valid32, in_ready32, mode32, cin_t32, cin_n32;
  logic        out_valid32, out_ready32, cout_t32, cout_n32, err32;
  logic [31:0] a_t32, a_n32, b_t32, b_n32, r_t32, r_n32, bo_t32, bo_n32;

  int n_tests = 0;
  int n_fail  = 0;

  rev_add_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a_t(a_t), .a_n(a_n), .b_t(b_t), .b_n(b_n), .cin_t(cin_t), .cin_n(cin_n),
    .out_valid(out_valid), .out_ready(out_ready), .r_t(r_t), .r_n(r_n),
    .bo_t(bo_t), .bo_n(bo_n), .cout_t(cout_t), .cout_n(cout_n), .err(err)
  );

  rev_add_seq #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .mode(mode32),
    .a_t(a_t32), .a_n(a_n32), .b_t(b_t32), .b_n(b_n32), .cin_t(cin_t32), .cin_n(cin_n32),
    .out_valid(out_valid32), .out_ready(out_ready32), .r_t(r_t32), .r_n(r_n32),
    .bo_t(bo_t32), .bo_n(bo_n32), .cout_t(cout_t32), .cout_n(cout_n32), .err(err32)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns one cycle after the accepting edge, with the inputs scrambled.
  task automatic start16(input logic m, input logic [15:0] at, input logic [15:0] an,
                         input logic [15:0] bt, input logic [15:0] bn,
                         input logic ct, input logic cn);
    int guard = 0;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    check_eq("ready_before_start", {63'd0, in_ready}, 64'd1);
    mode = m; a_t = at; a_n = an; b_t = bt; b_n = bn; cin_t = ct; cin_n = cn;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode = ~m; a_t = 16'($urandom); a_n = 16'($urandom);
    b_t = 16'($urandom); b_n = 16'($urandom); cin_t = ~ct; cin_n = ct;
  endtask

  task automatic wait_done16(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check_eq("done_reached", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic release16();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic op16(input string tag, input logic m, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [15:0] exp_r, input logic exp_co);
    int lat;
    start16(m, a, ~a, b, ~b, c, ~c);
    wait_done16(lat);
    check_eq({tag, "_lat"},  64'(lat), 64'd6);
    check_eq({tag, "_r"},    {r_t, r_n}, {exp_r, ~exp_r});
    check_eq({tag, "_cout"}, {cout_t, cout_n}, {exp_co, ~exp_co});
    check_eq({tag, "_bo"},   {bo_t, bo_n}, {b, ~b});
    check_eq({tag, "_err"},  {63'd0, err}, 64'd0);
    release16();
  endtask

  initial begin
    int lat;
    logic saw;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
    a_t = '0; a_n = '0; b_t = '0; b_n = '0; cin_t = 1'b0; cin_n = 1'b1;
    in_valid32 = 1'b0; out_ready32 = 1'b0; mode32 = 1'b0;
    a_t32 = '0; a_n32 = '0; b_t32 = '0; b_n32 = '0; cin_t32 = 1'b0; cin_n32 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    check_eq("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_err",       {63'd0, err}, 64'd0);
    check_eq("rst_rails",     {r_t, r_n, bo_t, bo_n}, 64'd0);
    check_eq("rst_cout",      {62'd0, cout_t, cout_n}, 64'd0);
    rst = 1'b0;

    // Forward add with ripple across three chunks, plus a stall in DONE.
    start16(1'b0, 16'h1234, ~16'h1234, 16'h0FFF, ~16'h0FFF, 1'b0, 1'b1);
    check_eq("busy_null_rails", {r_t, r_n, bo_t, bo_n}, 64'd0);
    check_eq("busy_in_ready",   {63'd0, in_ready}, 64'd0);
    wait_done16(lat);
    check_eq("fwd1_lat",  64'(lat), 64'd6);
    check_eq("fwd1_r",    {r_t, r_n}, {16'h2233, 16'hDDCC});
    check_eq("fwd1_cout", {cout_t, cout_n}, 2'b01);
    check_eq("fwd1_bo",   {bo_t, bo_n}, {16'h0FFF, 16'hF000});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("stall_r",     {r_t, r_n, cout_t, cout_n}, {16'h2233, 16'hDDCC, 2'b01});
      check_eq("stall_hs",    {62'd0, in_ready, out_valid}, 64'b01);
    end
    release16();
    check_eq("post_rel_hs",    {62'd0, in_ready, out_valid}, 64'b10);
    check_eq("post_rel_rails", {r_t, r_n, bo_t, bo_n}, 64'd0);

    // Carry-out boundary, then uncompute with the same B and cin.
    op16("fwd2", 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1);
    op16("bwd2", 1'b1, 16'h0001, 16'h0001, 1'b1, 16'hFFFF, 1'b1);
    op16("fwd3", 1'b0, 16'hBEEF, 16'h1357, 1'b1, 16'hD247, 1'b0);
    op16("bwd3", 1'b1, 16'hD247, 16'h1357, 1'b1, 16'hBEEF, 1'b0);

    // Invalid code on A bit 5 (both rails high).
    start16(1'b0, 16'h1234 | 16'h0020, ~16'h1234 | 16'h0020, 16'h00F0, ~16'h00F0, 1'b0, 1'b1);
    wait_done16(lat);
    check_eq("inv_a_lat",  64'(lat), 64'd2);
    check_eq("inv_a_err",  {63'd0, err}, 64'd1);
    check_eq("inv_a_r",    {r_t, r_n, cout_t, cout_n}, 34'd0);
    check_eq("inv_a_bo",   {bo_t, bo_n}, {16'h00F0, 16'hFF0F});
    release16();
    check_eq("inv_a_clear", {62'd0, err, out_valid}, 64'd0);

    // Invalid code on cin (both rails low).
    start16(1'b1, 16'h0005, ~16'h0005, 16'h0003, ~16'h0003, 1'b0, 1'b0);
    wait_done16(lat);
    check_eq("inv_c_lat", 64'(lat), 64'd2);
    check_eq("inv_c_err", {63'd0, err}, 64'd1);
    release16();

    // Reset during RUN at chunk 2 aborts the operation.
    start16(1'b0, 16'hAAAA, ~16'hAAAA, 16'h1111, ~16'h1111, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_in_ready", {63'd0, in_ready}, 64'd1);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw = saw | out_valid;
      @(posedge clk); #1;
    end
    check_eq("abort_no_valid", {63'd0, saw}, 64'd0);
    op16("after_abort", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

    // 32-bit / 8-bit chunks: backward 0 - 1 wraps with borrow.
    mode32 = 1'b1; a_t32 = 32'h0; a_n32 = ~32'h0; b_t32 = 32'h1; b_n32 = ~32'h1;
    cin_t32 = 1'b0; cin_n32 = 1'b1; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0; a_t32 = 32'($urandom); b_t32 = 32'($urandom);
    lat = 1;
    while (!out_valid32 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check_eq("w32_done", {63'd0, out_valid32}, 64'd1);
    check_eq("w32_lat",  64'(lat), 64'd6);
    check_eq("w32_r",    {r_t32, r_n32}, {32'hFFFF_FFFF, 32'h0});
    check_eq("w32_cout", {cout_t32, cout_n32}, 2'b10);
    check_eq("w32_bo",   {bo_t32, bo_n32}, {32'h1, 32'hFFFF_FFFE});
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    check_eq("w32_idle", {62'd0, in_ready32, out_valid32}, 64'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
